keypad_scan_ctrl: RTL
=====================

Name: keypad_scan_ctrl

Overview:
- Scan sequencer for the 4x4 matrix keypad.
- Drives active-low column strobes and samples the active-low row lines once per column dwell.
- Debounces all 16 keys and maps each key to its hex key code.
- Queues press events in a 4-entry FIFO with a valid/ready pop handshake, and exports live key-down state for the LED layer.

Parameters:
SCAN_DIV, 5, clock cycles per column dwell; legal range 4..255.
DEBOUNCE_SCANS, 3, consecutive disagreeing samples needed to change a key's debounced state; legal range 1..15.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
scan_en  input  1  1 = scanning runs; 0 = scan frozen
row  input  4  keypad row lines, active low
col  output  4  column strobe, one bit low while scanning
key_down  output  16  debounced pressed state, indexed by key code
key_valid  output  1  FIFO non-empty
key_code  output  4  key code at the FIFO head
key_ready  input  1  consumer accepts the head entry
overflow  output  1  sticky flag: a press event was dropped

Behaviour:
- Reset (synchronous, reset=1 at a clk edge):
  - col=4'b1110, column index=0, dwell counter=0.
  - All debounce counters=0, key_down=0.
  - FIFO empty, key_valid=0, key_code=0, overflow=0, pending=0.
- Scan:
  - Column index c (0..3) drives col=~(1<<c).
  - Dwell counter runs 0..SCAN_DIV-1. At count SCAN_DIV-1: row is sampled, c advances (3 wraps to 0), counter returns to 0.
  - One frame = 4*SCAN_DIV cycles.
- Key map (column index, row index 0..3 -> code):
  - c0: d, c, b, a
  - c1: f, 9, 6, 3
  - c2: 0, 8, 5, 2
  - c3: e, 7, 4, 1
- Debounce, per key at its sample:
  - raw = ~row[r].
  - If raw == key_down[code]: counter cleared.
  - Else if counter == DEBOUNCE_SCANS-1: key_down[code] <= raw, counter cleared, event confirmed.
  - Else: counter incremented.
  - A change therefore needs DEBOUNCE_SCANS consecutive differing samples; any agreeing sample restarts the count.
- Events:
  - Only a press confirmation (0 -> 1) sets pending[r]. A release updates key_down only.
  - Pending is drained one entry per cycle, lowest row first, starting the cycle after the sample. Its stored code is taken from the sampled column.
  - SCAN_DIV >= 4 guarantees pending is empty before the next sample.
- FIFO (depth 4):
  - key_valid = !empty; key_code = head.
  - Pop when key_valid && key_ready.
  - Push when pending && (!full || pop in the same cycle). A simultaneous push and pop while full is accepted and count stays 4.
  - Push while full without a pop: the event is dropped, its pending bit is cleared, and overflow is set to 1. overflow clears only on reset.
  - Pointers wrap modulo 4.
- scan_en=0:
  - col=4'b1111 from the next cycle; no sampling.
  - Debounce state, key_down, pending drain and FIFO operation continue unaffected.
  - When scan_en returns to 1: c=0, counter=0, col=1110 the next cycle.
- Reset during a dwell or with the FIFO non-empty: all state returns to reset values the following cycle, and queued codes are discarded.

Test Plan:
1. Reset for 1 cycle, row=1111 -> col=1110; col steps 1101/1011/0111 every 5 cycles and repeats with period 20; key_valid=0; key_down=0.
2. row=1110 whenever col==1110, held for 3 frames, key_ready=0 -> key_down[13]=1 at the third sample; key_valid=1 with key_code=4'hd 2 cycles later; exactly one entry; overflow=0.
3. Same key held for only 2 frames, then released -> key_down stays 0, key_valid stays 0.
4. row=0110 while col==1101, held for 3 frames -> two entries popped in order 4'hf, then 4'h3; key_down[15]=key_down[3]=1.
5. key_ready=0; press and release 5 distinct keys sequentially (codes 1,2,3,4,5) -> key_down=0 afterwards; overflow=1; popping returns 1,2,3,4, then key_valid=0.
6. Key 4'hd pressed and queued; scan_en=0 for 30 cycles, then 1 -> col=1111 during the hold; key_down[13] stays 1; FIFO entry intact; scanning restarts at col=1110.

Source files
------------

// File: rtl/keypad_scan_if.sv
// Keypad scanner bus: matrix strobe/sense lines, live key state and the
// press-event pop handshake. The master side is the keypad/consumer.
interface keypad_scan_if;
    logic        scan_en;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] key_down;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_ready;
    logic        overflow;

    modport master (
        output scan_en, row, key_ready,
        input  col, key_down, key_valid, key_code, overflow
    );

    modport slave (
        input  scan_en, row, key_ready,
        output col, key_down, key_valid, key_code, overflow
    );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scan sequencer: column strobing, per-key debounce, hex key mapping
// and a 4-deep press-event FIFO with a valid/ready pop.
module keypad_scan_ctrl #(
    parameter int unsigned SCAN_DIV       = 5,
    parameter int unsigned DEBOUNCE_SCANS = 3
) (
    input  logic         clk,
    input  logic         reset,
    keypad_scan_if.slave kp
);

    // state     | meaning
    // ST_SCAN   | strobes cycling, row sampled at the last cycle of each dwell
    // ST_FROZEN | scan_en low: all strobes released (1111), no sampling
    typedef enum logic {
        ST_SCAN   = 1'b0,
        ST_FROZEN = 1'b1
    } state_t;

    localparam logic [7:0] DWELL_LAST = 8'(SCAN_DIV - 1);
    localparam logic [3:0] DB_LAST    = 4'(DEBOUNCE_SCANS - 1);

    state_t      state_q, state_d;
    logic [1:0]  col_idx_q, col_idx_d;
    logic [3:0]  col_q, col_d;
    logic [7:0]  dwell_q, dwell_d;
    logic [15:0] key_down_q, key_down_d;
    logic [3:0]  db_q [16];
    logic [3:0]  db_d [16];
    logic [3:0]  pend_q, pend_d;
    logic [1:0]  pend_col_q, pend_col_d;
    logic [3:0]  fifo_q [4];
    logic [3:0]  fifo_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        overflow_q, overflow_d;

    logic        sample;
    logic        pop;
    logic        push;
    logic        push_req;
    logic [1:0]  nxt_idx;
    logic [1:0]  drain_row;
    logic [3:0]  drain_mask;
    logic [3:0]  new_press;
    logic [3:0]  push_code;
    logic [3:0]  code;
    logic        raw;

    function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
        logic [3:0] k;
        case ({c, r})
            4'h0: k = 4'hd;
            4'h1: k = 4'hc;
            4'h2: k = 4'hb;
            4'h3: k = 4'ha;
            4'h4: k = 4'hf;
            4'h5: k = 4'h9;
            4'h6: k = 4'h6;
            4'h7: k = 4'h3;
            4'h8: k = 4'h0;
            4'h9: k = 4'h8;
            4'ha: k = 4'h5;
            4'hb: k = 4'h2;
            4'hc: k = 4'he;
            4'hd: k = 4'h7;
            4'he: k = 4'h4;
            default: k = 4'h1;
        endcase
        return k;
    endfunction

    always_comb begin
        state_d    = state_q;
        col_idx_d  = col_idx_q;
        col_d      = col_q;
        dwell_d    = dwell_q;
        key_down_d = key_down_q;
        db_d       = db_q;
        pend_col_d = pend_col_q;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        sample     = 1'b0;
        new_press  = 4'b0000;
        code       = 4'h0;
        raw        = 1'b0;
        nxt_idx    = col_idx_q + 2'd1;

        case (state_q)
            ST_FROZEN: begin
                if (kp.scan_en) begin
                    state_d   = ST_SCAN;
                    col_idx_d = 2'd0;
                    col_d     = 4'b1110;
                    dwell_d   = DWELL_LAST;
                end
            end
            default: begin
                if (!kp.scan_en) begin
                    state_d   = ST_FROZEN;
                    col_idx_d = 2'd0;
                    col_d     = 4'b1111;
                    dwell_d   = DWELL_LAST;
                end else if (dwell_q == 8'd0) begin
                    sample    = 1'b1;
                    col_idx_d = nxt_idx;
                    col_d     = ~(4'b0001 << nxt_idx);
                    dwell_d   = DWELL_LAST;
                end else begin
                    dwell_d = dwell_q - 8'd1;
                end
            end
        endcase

        // Counter holds the run length of samples disagreeing with key_down.
        for (int r = 0; r < 4; r++) begin
            code = key_map(col_idx_q, 2'(r));
            raw  = ~kp.row[r];
            if (sample) begin
                if (raw == key_down_q[code]) begin
                    db_d[code] = 4'd0;
                end else if (db_q[code] == DB_LAST) begin
                    key_down_d[code] = raw;
                    db_d[code]       = 4'd0;
                    new_press[r]     = raw;
                end else begin
                    db_d[code] = db_q[code] + 4'd1;
                end
            end
        end

        push_req  = |pend_q;
        drain_row = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (pend_q[r]) drain_row = 2'(r);
        end
        drain_mask = push_req ? (4'b0001 << drain_row) : 4'b0000;
        push_code  = key_map(pend_col_q, drain_row);

        pop  = (count_q != 3'd0) && kp.key_ready;
        push = push_req && ((count_q != 3'd4) || pop);

        // The pending bit is retired whether the event lands or is dropped.
        pend_d = (pend_q & ~drain_mask) | new_press;
        if (sample) pend_col_d = col_idx_q;
        if (push_req && !push) overflow_d = 1'b1;

        if (push) begin
            fifo_d[wr_ptr_q] = push_code;
            wr_ptr_d         = wr_ptr_q + 2'd1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 2'd1;

        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_SCAN;
            col_idx_q  <= 2'd0;
            col_q      <= 4'b1110;
            dwell_q    <= DWELL_LAST;
            key_down_q <= 16'h0000;
            for (int i = 0; i < 16; i++) db_q[i] <= 4'd0;
            pend_q     <= 4'b0000;
            pend_col_q <= 2'd0;
            for (int i = 0; i < 4; i++) fifo_q[i] <= 4'h0;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_idx_q  <= col_idx_d;
            col_q      <= col_d;
            dwell_q    <= dwell_d;
            key_down_q <= key_down_d;
            db_q       <= db_d;
            pend_q     <= pend_d;
            pend_col_q <= pend_col_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign kp.col       = col_q;
    assign kp.key_down  = key_down_q;
    assign kp.key_valid = (count_q != 3'd0);
    assign kp.key_code  = fifo_q[rd_ptr_q];
    assign kp.overflow  = overflow_q;

endmodule
